corescore_reset_seq: RTL and testbench

- Reset sequencer sitting directly downstream of the board clock generator, in the generated system clock domain.
- Takes a raw asynchronous active-low reset and produces staged, glitch-free resets:
  - peripheral reset first (UART/emitter path),
  - core reset after a stagger delay,
  - a ready flag once both are released.
- Also restarts the sequence on a software reset request.

---
 rtl/corescore_reset_seq.sv | 185 ++++++++++++++++++
 tb/tb_corescore_reset_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/corescore_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : corescore_reset_seq
// Purpose  : Staged reset sequencer for the generated system clock domain.
//            A raw asynchronous active-low reset is synchronised on release,
//            then the peripheral reset is released after a hold period and
//            the core reset after a further stagger. o_ready reports that
//            both resets are released. A software request restarts the
//            whole sequence from the hold period.
// Option   : `define CORESCORE_RESET_SEQ_WDT_EN builds a watchdog that runs
//            in RUN. It is cleared by i_kick and restarts the sequence on
//            timeout, setting the sticky o_wdt_fired flag. When the macro
//            is not defined, i_kick is unused and o_wdt_fired is 0.
// Ports    : i_clk        system clock (generated clock)
//            i_rst_n      async active-low reset, released through synchroniser
//            i_sw_rst     software reset request, level-sampled, honoured in RUN
//            i_kick       watchdog kick (watchdog build only)
//            o_rst_periph active-high peripheral reset (released first)
//            o_rst_core   active-high core reset (released after the stagger)
//            o_ready      both resets released
//            o_wdt_fired  sticky watchdog-timeout flag
// Revision : 1.0  initial release
// ============================================================================
module corescore_reset_seq #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int WDT_CYCLES     = 1048576,
  parameter int CNT_W          = 21
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sw_rst,
  input  logic i_kick,
  output logic o_rst_periph,
  output logic o_rst_core,
  output logic o_ready,
  output logic o_wdt_fired
);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STAGGER = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  // Terminal counts. The stagger value is clamped so that a zero stagger
  // does not produce a negative constant; that state is never entered then.
  localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_stag_last =
    CNT_W'((STAGGER_CYCLES == 0) ? 0 : (STAGGER_CYCLES - 1));
`ifdef CORESCORE_RESET_SEQ_WDT_EN
  localparam logic [CNT_W-1:0] c_wdt_last  = CNT_W'(WDT_CYCLES - 1);
`else
  localparam int               c_unused_wdt_cycles = WDT_CYCLES;
  logic w_unused_kick;
  assign w_unused_kick = i_kick;
`endif

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rst_periph_q, rst_periph_d;
  logic                   rst_core_q, rst_core_d;
  logic                   ready_q, ready_d;
`ifdef CORESCORE_RESET_SEQ_WDT_EN
  logic                   wdt_fired_q, wdt_fired_d;
`endif

  always_comb begin
    // The synchroniser only ever shifts in ones; it is cleared solely by
    // the asynchronous reset, so its last stage stays high once released.
    sync_d       = {sync_q[SYNC_STAGES-2:0], 1'b1};
    state_d      = state_q;
    cnt_d        = cnt_q;
    rst_periph_d = rst_periph_q;
    rst_core_d   = rst_core_q;
    ready_d      = ready_q;
`ifdef CORESCORE_RESET_SEQ_WDT_EN
    wdt_fired_d  = wdt_fired_q;
`endif

    // Nothing advances until the synchronised release has been seen.
    if (sync_q[SYNC_STAGES-1]) begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == c_hold_last) begin
            cnt_d        = '0;
            rst_periph_d = 1'b0;
            if (STAGGER_CYCLES == 0) begin
              rst_core_d = 1'b0;
              ready_d    = 1'b1;
              state_d    = ST_RUN;
            end else begin
              state_d    = ST_STAGGER;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_STAGGER: begin
          if (cnt_q == c_stag_last) begin
            // Counter returns to zero on entry to RUN, which also starts
            // the watchdog interval from zero.
            cnt_d      = '0;
            rst_core_d = 1'b0;
            ready_d    = 1'b1;
            state_d    = ST_RUN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_RUN: begin
          if (i_sw_rst) begin
            cnt_d        = '0;
            rst_periph_d = 1'b1;
            rst_core_d   = 1'b1;
            ready_d      = 1'b0;
            state_d      = ST_HOLD;
          end
`ifdef CORESCORE_RESET_SEQ_WDT_EN
          // In RUN the counter is reused as the watchdog interval counter.
          else if (i_kick) begin
            cnt_d = '0;
          end else if (cnt_q == c_wdt_last) begin
            cnt_d        = '0;
            rst_periph_d = 1'b1;
            rst_core_d   = 1'b1;
            ready_d      = 1'b0;
            state_d      = ST_HOLD;
            wdt_fired_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end

        default: begin
          cnt_d        = '0;
          rst_periph_d = 1'b1;
          rst_core_d   = 1'b1;
          ready_d      = 1'b0;
          state_d      = ST_HOLD;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q       <= '0;
      state_q      <= ST_HOLD;
      cnt_q        <= '0;
      rst_periph_q <= 1'b1;
      rst_core_q   <= 1'b1;
      ready_q      <= 1'b0;
`ifdef CORESCORE_RESET_SEQ_WDT_EN
      wdt_fired_q  <= 1'b0;
`endif
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rst_periph_q <= rst_periph_d;
      rst_core_q   <= rst_core_d;
      ready_q      <= ready_d;
`ifdef CORESCORE_RESET_SEQ_WDT_EN
      wdt_fired_q  <= wdt_fired_d;
`endif
    end
  end

  assign o_rst_periph = rst_periph_q;
  assign o_rst_core   = rst_core_q;
  assign o_ready      = ready_q;
`ifdef CORESCORE_RESET_SEQ_WDT_EN
  assign o_wdt_fired  = wdt_fired_q;
`else
  assign o_wdt_fired  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_corescore_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_corescore_reset_seq
// Purpose  : Self-checking bench for corescore_reset_seq. Instance 0 uses the
//            default hold/stagger, instance 1 uses a zero stagger; both use
//            a 32-cycle watchdog. A timing model expressed as "edges elapsed
//            since the sequence origin" predicts every output each cycle,
//            and directed checks pin the edge numbers by hand.
// Revision : 1.0  initial release
// ============================================================================
module tb_corescore_reset_seq;

`ifdef CORESCORE_RESET_SEQ_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif
  localparam int P_SYNC = 2;
  localparam int P_HOLD = 16;
  localparam int P_WDT  = 32;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic sw_rst = 1'b0;
  logic kick   = 1'b0;
  logic [1:0] periph, core, ready, fired;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  corescore_reset_seq #(
    .SYNC_STAGES(P_SYNC), .HOLD_CYCLES(P_HOLD), .STAGGER_CYCLES(4),
    .WDT_CYCLES(P_WDT), .CNT_W(21)
  ) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sw_rst(sw_rst), .i_kick(kick),
    .o_rst_periph(periph[0]), .o_rst_core(core[0]),
    .o_ready(ready[0]), .o_wdt_fired(fired[0])
  );

  corescore_reset_seq #(
    .SYNC_STAGES(P_SYNC), .HOLD_CYCLES(P_HOLD), .STAGGER_CYCLES(0),
    .WDT_CYCLES(P_WDT), .CNT_W(21)
  ) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sw_rst(sw_rst), .i_kick(kick),
    .o_rst_periph(periph[1]), .o_rst_core(core[1]),
    .o_ready(ready[1]), .o_wdt_fired(fired[1])
  );

  // ---------------- timing model ----------------
  // m_ph: edges since the sequence origin (-1 before the synchronised
  // release); outputs follow purely from comparing it with the durations.
  int m_stag [2] = '{4, 0};
  int m_hi   [2] = '{0, 0};
  int m_ph   [2] = '{-1, -1};
  int m_idle [2] = '{0, 0};
  bit m_fired[2] = '{1'b0, 1'b0};
  bit m_run;

  function automatic bit exp_periph(int i);
    return m_ph[i] < P_HOLD;
  endfunction
  function automatic bit exp_core(int i);
    return m_ph[i] < (P_HOLD + m_stag[i]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_hi[i] = 0; m_ph[i] = -1; m_idle[i] = 0; m_fired[i] = 1'b0;
      end else begin
        m_run = !exp_core(i);
        if (m_ph[i] < 0) begin
          m_hi[i]++;
          if (m_hi[i] == P_SYNC) m_ph[i] = 0;
          m_idle[i] = 0;
        end else if (m_run && sw_rst) begin
          m_ph[i] = 0; m_idle[i] = 0;
        end else if (WDT_ON && m_run && !kick && m_idle[i] == P_WDT - 1) begin
          m_ph[i] = 0; m_idle[i] = 0; m_fired[i] = 1'b1;
        end else begin
          if (m_ph[i] < 1000000) m_ph[i]++;
          m_idle[i] = (m_run && !kick) ? m_idle[i] + 1 : 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (periph[i] !== exp_periph(i) || core[i] !== exp_core(i) ||
            ready[i] !== !exp_core(i) || fired[i] !== m_fired[i]) begin
          fails++;
          $display("FAIL model_cmp inst%0d t=%0t got p/c/r/w=%b%b%b%b required %b%b%b%b",
                   i, $time, periph[i], core[i], ready[i], fired[i],
                   exp_periph(i), exp_core(i), !exp_core(i), m_fired[i]);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got %b required %b", name, $time, act, exp);
    end
  endtask

  // Wait n rising edges, then settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Request is sampled by exactly one edge; returns 1 ns after that edge.
  task automatic sw_pulse();
    sw_rst = 1'b1;
    step(1);
    sw_rst = 1'b0;
  endtask

  initial begin
    cmp_en = 1'b1;
    step(3);
    chk("reset_periph", periph[0], 1'b1);
    chk("reset_core",   core[0],   1'b1);
    chk("reset_ready",  ready[0],  1'b0);
    chk("reset_wdt",    fired[0],  1'b0);

    // Power-up: S is the 2nd edge with rst_n high.
    rst_n = 1'b1;
    step(2);
    chk("pwr_S_periph", periph[0], 1'b1);
    step(15);
    chk("pwr_S15_periph", periph[0], 1'b1);
    chk("pwr_S15_z_core", core[1],   1'b1);
    step(1);
    chk("pwr_S16_periph", periph[0], 1'b0);
    chk("pwr_S16_core",   core[0],   1'b1);
    chk("pwr_S16_z_core", core[1],   1'b0);
    chk("pwr_S16_z_rdy",  ready[1],  1'b1);
    step(3);
    chk("pwr_S19_core",   core[0],   1'b1);
    step(1);
    chk("pwr_S20_core",   core[0],   1'b0);
    chk("pwr_S20_ready",  ready[0],  1'b1);

    // Software reset in RUN, full replay.
    step(5);
    sw_pulse();
    chk("sw_E_periph", periph[0], 1'b1);
    chk("sw_E_core",   core[0],   1'b1);
    chk("sw_E_ready",  ready[0],  1'b0);
    chk("sw_E_z_rdy",  ready[1],  1'b0);
    step(15);
    chk("sw_E15_periph", periph[0], 1'b1);
    step(1);
    chk("sw_E16_periph", periph[0], 1'b0);
    step(4);
    chk("sw_E20_ready",  ready[0],  1'b1);

    // Software request during HOLD neither restarts nor extends.
    step(3);
    sw_pulse();
    step(5);
    sw_pulse();
    step(9);
    chk("hold_sw_E15_periph", periph[0], 1'b1);
    step(1);
    chk("hold_sw_E16_periph", periph[0], 1'b0);
    step(4);
    chk("hold_sw_E20_ready",  ready[0],  1'b1);

    // Asynchronous reset mid-STAGGER, between clock edges.
    step(3);
    sw_pulse();
    step(17);
    chk("stag_periph", periph[0], 1'b0);
    chk("stag_core",   core[0],   1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_periph", periph[0], 1'b1);
    chk("async_core",   core[0],   1'b1);
    chk("async_z_rdy",  ready[1],  1'b0);
    step(2);
    rst_n = 1'b1;
    step(2);
    chk("rel_S_periph",   periph[0], 1'b1);
    step(15);
    chk("rel_S15_periph", periph[0], 1'b1);
    step(1);
    chk("rel_S16_periph", periph[0], 1'b0);
    step(4);
    chk("rel_S20_ready",  ready[0],  1'b1);

`ifdef CORESCORE_RESET_SEQ_WDT_EN
    for (int k = 0; k < 5; k++) begin
      kick = 1'b1;
      step(1);
      kick = 1'b0;
      step(19);
    end
    chk("wdt_kicked_ready", ready[0], 1'b1);
    chk("wdt_kicked_fired", fired[0], 1'b0);
    step(12);
    chk("wdt_K31_ready", ready[0], 1'b1);
    step(1);
    chk("wdt_K32_fired",  fired[0],  1'b1);
    chk("wdt_K32_periph", periph[0], 1'b1);
    chk("wdt_K32_ready",  ready[0],  1'b0);
    step(16);
    chk("wdt_K48_periph", periph[0], 1'b0);
    step(4);
    chk("wdt_K52_ready",  ready[0],  1'b1);
    chk("wdt_K52_fired",  fired[0],  1'b1);
    // Kick and software request together: the request wins.
    kick = 1'b1;
    sw_rst = 1'b1;
    step(1);
    kick = 1'b0;
    sw_rst = 1'b0;
    chk("wdt_prec_periph", periph[0], 1'b1);
    chk("wdt_sticky_sw",   fired[0],  1'b1);
    step(20);
    chk("wdt_sticky_run",  fired[0],  1'b1);
    rst_n = 1'b0;
    #1;
    chk("wdt_clr_rst",     fired[0],  1'b0);
    step(2);
    rst_n = 1'b1;
    step(30);
`else
    kick = 1'b0;
    step(2000);
    chk("nowdt_ready",  ready[0], 1'b1);
    chk("nowdt_fired0", fired[0], 1'b0);
    chk("nowdt_fired1", fired[1], 1'b0);
    kick = 1'b1;
    step(1);
    kick = 1'b0;
    step(40);
    chk("nowdt_kick_ignored", ready[0], 1'b1);
`endif

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
